led_matrix_fb_writer: RTL and testbench

Write side of the LED matrix frame buffer. It accepts a raster-ordered RGB444 pixel stream over a valid/ready handshake and writes each pixel into the two-bank frame RAM that the panel driver scans, splitting rows 0–31 into bank 1 and rows 32–63 into bank 2. Double buffering is by page. The block writes the back page and swaps pages only on the display's end-of-frame pulse, so the panel never shows a partial frame.

---
 rtl/led_matrix_pkg.sv | 38 +++
 rtl/led_fb_gamma.sv | 22 ++
 rtl/led_matrix_fb_writer.sv | 172 +++++++++++++++++
 tb/tb_led_matrix_fb_writer.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_matrix_pkg.sv
`default_nettype none
// ============================================================================
// Module   : led_matrix_pkg
// Purpose  : Shared definitions for the LED matrix frame-buffer write path:
//            default geometry, address field widths, writer FSM state type
//            and the 16-entry per-channel gamma table.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package led_matrix_pkg;

  localparam int C_COLS_DEFAULT = 48;
  localparam int C_ROWS_DEFAULT = 64;

  // Address = {page, row_sel[4:0], col[5:0]}
  localparam int C_COL_W     = 6;
  localparam int C_ROW_SEL_W = 5;
  localparam int C_ROW_W     = C_ROW_SEL_W + 1;  // extra MSB selects the bank
  localparam int C_ADDR_W    = 1 + C_ROW_SEL_W + C_COL_W;
  localparam int C_PIX_W     = 12;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITE     = 2'd1,
    ST_WAIT_SWAP = 2'd2
  } fb_state_t;

  localparam logic [3:0] C_GAMMA_LUT [16] = '{
    4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd2, 4'd3,
    4'd4, 4'd5, 4'd6, 4'd8, 4'd9, 4'd11, 4'd13, 4'd15
  };

  function automatic logic [3:0] gamma4(input logic [3:0] v);
    return C_GAMMA_LUT[v];
  endfunction

endpackage
`default_nettype wire

// File: rtl/led_fb_gamma.sv
`default_nettype none
// ============================================================================
// Module   : led_fb_gamma
// Purpose  : Combinational per-channel gamma correction of an RGB444 pixel
//            using the shared 16-entry table.
// Ports    : i_data [11:0] - pixel {R,G,B} in
//            o_data [11:0] - corrected pixel {R,G,B} out
// Revision : 1.0 - initial release
// ============================================================================
module led_fb_gamma
  import led_matrix_pkg::*;
(
  input  logic [C_PIX_W-1:0] i_data,
  output logic [C_PIX_W-1:0] o_data
);

  for (genvar g = 0; g < 3; g++) begin : g_ch
    assign o_data[g*4 +: 4] = gamma4(i_data[g*4 +: 4]);
  end

endmodule
`default_nettype wire

// File: rtl/led_matrix_fb_writer.sv
`default_nettype none
// ============================================================================
// Module   : led_matrix_fb_writer
// Purpose  : Write side of the double-buffered LED matrix frame RAM. Accepts
//            a raster-ordered RGB444 stream, writes the back page (rows 0-31
//            to bank 1, rows 32-63 to bank 2) and swaps pages only on the
//            display's end-of-frame pulse.
// Ports    : i_clk, i_rst (async, active-high)
//            i_pix_data/i_pix_valid/i_pix_sof/o_pix_ready - pixel stream
//            o_wr_addr/o_wr_data/o_wr_b1_en/o_wr_b2_en     - RAM write port
//            i_frame_done   - display end-of-frame pulse
//            o_display_page - page currently scanned by the display
//            o_swap_pending - full frame waiting for a swap
//            o_sof_err      - sticky mid-frame SOF flag
// Config   : LED_FB_GAMMA_EN - route pixel data through led_fb_gamma
// Revision : 1.0 - initial release
// ============================================================================
module led_matrix_fb_writer
  import led_matrix_pkg::*;
#(
  parameter int COLS = C_COLS_DEFAULT,
  parameter int ROWS = C_ROWS_DEFAULT
)
(
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [C_PIX_W-1:0]  i_pix_data,
  input  logic                i_pix_valid,
  input  logic                i_pix_sof,
  output logic                o_pix_ready,
  output logic [C_ADDR_W-1:0] o_wr_addr,
  output logic [C_PIX_W-1:0]  o_wr_data,
  output logic                o_wr_b1_en,
  output logic                o_wr_b2_en,
  input  logic                i_frame_done,
  output logic                o_display_page,
  output logic                o_swap_pending,
  output logic                o_sof_err
);

  localparam logic [C_COL_W-1:0] C_LAST_COL = C_COL_W'(COLS - 1);
  localparam logic [C_ROW_W-1:0] C_LAST_ROW = C_ROW_W'(ROWS - 1);

  fb_state_t r_state, w_state_nxt;
  logic [C_COL_W-1:0]  r_col, w_col_nxt, w_wcol;
  logic [C_ROW_W-1:0]  r_row, w_row_nxt, w_wrow;
  logic                r_page, w_page_nxt;
  logic                r_sof_err, w_sof_err_nxt;
  logic                r_ready;
  logic                w_accept;
  logic                w_we;
  logic [C_PIX_W-1:0]  w_pix_data;
  logic [C_ADDR_W-1:0] r_wr_addr;
  logic [C_PIX_W-1:0]  r_wr_data;
  logic                r_wr_b1_en, r_wr_b2_en;

`ifdef LED_FB_GAMMA_EN
  led_fb_gamma u_gamma (
    .i_data (i_pix_data),
    .o_data (w_pix_data)
  );
`else
  assign w_pix_data = i_pix_data;
`endif

  assign w_accept = i_pix_valid & r_ready;

  // Next-state / write decision. w_wrow/w_wcol is the position the current
  // pixel lands at; a SOF always lands at (0,0) and leaves col at 1.
  always_comb begin
    w_state_nxt   = r_state;
    w_col_nxt     = r_col;
    w_row_nxt     = r_row;
    w_page_nxt    = r_page;
    w_sof_err_nxt = r_sof_err;
    w_we          = 1'b0;
    w_wcol        = r_col;
    w_wrow        = r_row;

    case (r_state)
      ST_IDLE: begin
        // Non-SOF pixels are accepted and dropped until a frame starts.
        if (w_accept && i_pix_sof) begin
          w_we        = 1'b1;
          w_wcol      = '0;
          w_wrow      = '0;
          w_col_nxt   = C_COL_W'(1);
          w_row_nxt   = '0;
          w_state_nxt = ST_WRITE;
        end
      end

      ST_WRITE: begin
        if (w_accept) begin
          w_we = 1'b1;
          if (i_pix_sof) begin
            // Resync: restart the frame from this pixel.
            w_sof_err_nxt = 1'b1;
            w_wcol        = '0;
            w_wrow        = '0;
            w_col_nxt     = C_COL_W'(1);
            w_row_nxt     = '0;
          end else if (r_col == C_LAST_COL) begin
            w_col_nxt = '0;
            if (r_row == C_LAST_ROW) begin
              w_row_nxt   = '0;
              w_state_nxt = ST_WAIT_SWAP;
            end else begin
              w_row_nxt = r_row + C_ROW_W'(1);
            end
          end else begin
            w_col_nxt = r_col + C_COL_W'(1);
          end
        end
      end

      ST_WAIT_SWAP: begin
        if (i_frame_done) begin
          w_page_nxt  = ~r_page;
          w_col_nxt   = '0;
          w_row_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_col      <= '0;
      r_row      <= '0;
      r_page     <= 1'b0;
      r_sof_err  <= 1'b0;
      r_ready    <= 1'b1;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_wr_b1_en <= 1'b0;
      r_wr_b2_en <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_col      <= w_col_nxt;
      r_row      <= w_row_nxt;
      r_page     <= w_page_nxt;
      r_sof_err  <= w_sof_err_nxt;
      // Ready is registered from the next state so it falls right after
      // the final pixel handshake.
      r_ready    <= (w_state_nxt != ST_WAIT_SWAP);
      // Row MSB picks the bank, so the two strobes are mutually exclusive.
      r_wr_b1_en <= w_we & ~w_wrow[C_ROW_W-1];
      r_wr_b2_en <= w_we &  w_wrow[C_ROW_W-1];
      if (w_we) begin
        // Writes always target the back page (the one not displayed).
        r_wr_addr <= {~r_page, w_wrow[C_ROW_SEL_W-1:0], w_wcol};
        r_wr_data <= w_pix_data;
      end
    end
  end

  assign o_pix_ready    = r_ready;
  assign o_wr_addr      = r_wr_addr;
  assign o_wr_data      = r_wr_data;
  assign o_wr_b1_en     = r_wr_b1_en;
  assign o_wr_b2_en     = r_wr_b2_en;
  assign o_display_page = r_page;
  assign o_swap_pending = (r_state == ST_WAIT_SWAP);
  assign o_sof_err      = r_sof_err;

endmodule
`default_nettype wire

// File: tb/tb_led_matrix_fb_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_matrix_fb_writer
// Purpose  : Self-checking bench for led_matrix_fb_writer. Random pixel data
//            is compared against a raster-position reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_matrix_fb_writer;

  localparam int COLS = 48;
  localparam int ROWS = 64;
  localparam int NPIX = COLS * ROWS;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [11:0] i_pix_data = '0;
  logic        i_pix_valid = 1'b0;
  logic        i_pix_sof = 1'b0;
  logic        o_pix_ready;
  logic [11:0] o_wr_addr;
  logic [11:0] o_wr_data;
  logic        o_wr_b1_en;
  logic        o_wr_b2_en;
  logic        i_frame_done = 1'b0;
  logic        o_display_page;
  logic        o_swap_pending;
  logic        o_sof_err;

  int   n_pass  = 0;
  int   n_total = 0;
  logic mdl_page = 1'b0;

  logic [3:0] gamma_ref [16] = '{0, 0, 0, 0, 1, 1, 2, 3, 4, 5, 6, 8, 9, 11, 13, 15};

  always #5 i_clk = ~i_clk;

  led_matrix_fb_writer #(.COLS(COLS), .ROWS(ROWS)) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_pix_data     (i_pix_data),
    .i_pix_valid    (i_pix_valid),
    .i_pix_sof      (i_pix_sof),
    .o_pix_ready    (o_pix_ready),
    .o_wr_addr      (o_wr_addr),
    .o_wr_data      (o_wr_data),
    .o_wr_b1_en     (o_wr_b1_en),
    .o_wr_b2_en     (o_wr_b2_en),
    .i_frame_done   (i_frame_done),
    .o_display_page (o_display_page),
    .o_swap_pending (o_swap_pending),
    .o_sof_err      (o_sof_err)
  );

  // ---------------- reference model ----------------
  function automatic logic [11:0] exp_addr(input logic wpage, input int n);
    int row = n / COLS;
    int col = n % COLS;
    return {wpage, 5'(row % 32), 6'(col)};
  endfunction

  function automatic logic exp_bank2(input int n);
    return (n / COLS) >= 32;
  endfunction

  function automatic logic [11:0] exp_data(input logic [11:0] d);
`ifdef LED_FB_GAMMA_EN
    return {gamma_ref[d[11:8]], gamma_ref[d[7:4]], gamma_ref[d[3:0]]};
`else
    return d;
`endif
  endfunction

  function automatic logic [25:0] exp_write(input int n, input logic [11:0] d);
    return {~exp_bank2(n), exp_bank2(n), exp_addr(~mdl_page, n), exp_data(d)};
  endfunction

  // ---------------- stimulus primitives ----------------
  task automatic drive_pix(input logic [11:0] d, input logic sof);
    i_pix_data  = d;
    i_pix_sof   = sof;
    i_pix_valid = 1'b1;
    @(posedge i_clk); #1;
    i_pix_valid = 1'b0;
    i_pix_sof   = 1'b0;
  endtask

  task automatic idle_cycle();
    i_pix_valid = 1'b0;
    @(posedge i_clk); #1;
  endtask

  task automatic pulse_frame_done();
    i_frame_done = 1'b1;
    @(posedge i_clk); #1;
    i_frame_done = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [29:0] obs;
    i_rst = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    obs = {o_pix_ready, o_display_page, o_wr_addr, o_wr_data, o_wr_b1_en, o_wr_b2_en, o_swap_pending, o_sof_err};
    n_total++;
    if (obs !== {1'b1, 1'b0, 12'h0, 12'h0, 4'b0000}) $display("FAIL reset_state got=%h want=%h", obs, {1'b1, 1'b0, 12'h0, 12'h0, 4'b0000});
    else n_pass++;
    i_rst = 1'b0;
    idle_cycle();
    n_total++;
    if ({o_pix_ready, o_wr_b1_en, o_wr_b2_en} !== 3'b100) $display("FAIL post_reset ready/en got=%b want=100", {o_pix_ready, o_wr_b1_en, o_wr_b2_en});
    else n_pass++;
  endtask

  task automatic test_full_frame();
    logic [11:0] d;
    logic [25:0] obs;
    logic [13:0] want_c;
    for (int n = 0; n < NPIX; n++) begin
      if (n > 0 && $urandom_range(0, 7) == 0) begin
        idle_cycle();
        n_total++;
        if ({o_wr_b1_en, o_wr_b2_en} !== 2'b00) $display("FAIL gap_no_write n=%0d en=%b want=00", n, {o_wr_b1_en, o_wr_b2_en});
        else n_pass++;
      end
      d = 12'($urandom);
      drive_pix(d, n == 0);
      obs = {o_wr_b1_en, o_wr_b2_en, o_wr_addr, o_wr_data};
      n_total++;
      if (obs !== exp_write(n, d)) $display("FAIL frame1_write n=%0d got=%h want=%h", n, obs, exp_write(n, d));
      else n_pass++;
      if (n == 0 || n == 1535 || n == 1536) begin
        want_c = (n == 0) ? {2'b10, 12'h800} : (n == 1535) ? {2'b10, 12'hFEF} : {2'b01, 12'h800};
        n_total++;
        if ({o_wr_b1_en, o_wr_b2_en, o_wr_addr} !== want_c) $display("FAIL landmark_addr n=%0d got=%h want=%h", n, {o_wr_b1_en, o_wr_b2_en, o_wr_addr}, want_c);
        else n_pass++;
      end
    end
    n_total++;
    if ({o_pix_ready, o_swap_pending} !== 2'b01) $display("FAIL frame_end ready/pending got=%b want=01", {o_pix_ready, o_swap_pending});
    else n_pass++;
    // Valid held high while waiting for the swap must not write anything.
    i_pix_valid = 1'b1;
    i_pix_data  = 12'($urandom);
    for (int k = 0; k < 3; k++) begin
      @(posedge i_clk); #1;
      n_total++;
      if ({o_pix_ready, o_wr_b1_en, o_wr_b2_en, o_display_page} !== {3'b000, mdl_page}) $display("FAIL wait_swap_hold k=%0d got=%b want=%b", k, {o_pix_ready, o_wr_b1_en, o_wr_b2_en, o_display_page}, {3'b000, mdl_page});
      else n_pass++;
    end
    i_pix_valid = 1'b0;
  endtask

  task automatic test_swap();
    logic [11:0] d;
    pulse_frame_done();
    mdl_page = ~mdl_page;
    n_total++;
    if ({o_display_page, o_pix_ready, o_swap_pending} !== 3'b110) $display("FAIL swap page/ready/pending got=%b want=110", {o_display_page, o_pix_ready, o_swap_pending});
    else n_pass++;
    d = 12'($urandom);
    drive_pix(d, 1'b1);
    n_total++;
    if ({o_wr_b1_en, o_wr_b2_en, o_wr_addr, o_wr_data} !== {2'b10, 12'h000, exp_data(d)}) $display("FAIL swap_first_write got=%h want=%h", {o_wr_b1_en, o_wr_b2_en, o_wr_addr, o_wr_data}, {2'b10, 12'h000, exp_data(d)});
    else n_pass++;
  endtask

  // Continues the frame opened by test_swap.
  task automatic test_early_frame_done();
    logic [11:0] d;
    logic [25:0] obs;
    for (int n = 1; n < NPIX; n++) begin
      d = 12'($urandom);
      i_frame_done = (n == 500) || (n == NPIX - 1);
      drive_pix(d, 1'b0);
      i_frame_done = 1'b0;
      obs = {o_wr_b1_en, o_wr_b2_en, o_wr_addr, o_wr_data};
      n_total++;
      if (obs !== exp_write(n, d)) $display("FAIL frame2_write n=%0d got=%h want=%h", n, obs, exp_write(n, d));
      else n_pass++;
      if (n == 500 || n == NPIX - 1) begin
        n_total++;
        if (o_display_page !== mdl_page) $display("FAIL early_fd_page n=%0d got=%b want=%b", n, o_display_page, mdl_page);
        else n_pass++;
      end
    end
    repeat (3) idle_cycle();
    n_total++;
    if ({o_swap_pending, o_display_page} !== {1'b1, mdl_page}) $display("FAIL coincident_fd_no_swap got=%b want=%b", {o_swap_pending, o_display_page}, {1'b1, mdl_page});
    else n_pass++;
    pulse_frame_done();
    mdl_page = ~mdl_page;
    n_total++;
    if ({o_display_page, o_swap_pending} !== {mdl_page, 1'b0}) $display("FAIL late_swap got=%b want=%b", {o_display_page, o_swap_pending}, {mdl_page, 1'b0});
    else n_pass++;
  endtask

  task automatic test_resync();
    logic [11:0] d;
    logic [25:0] obs;
    for (int n = 0; n < 100; n++) begin
      d = 12'($urandom);
      drive_pix(d, n == 0);
      obs = {o_wr_b1_en, o_wr_b2_en, o_wr_addr, o_wr_data};
      n_total++;
      if (obs !== exp_write(n, d)) $display("FAIL pre_resync_write n=%0d got=%h want=%h", n, obs, exp_write(n, d));
      else n_pass++;
    end
    n_total++;
    if (o_sof_err !== 1'b0) $display("FAIL sof_err_early got=%b want=0", o_sof_err);
    else n_pass++;
    d = 12'($urandom);
    drive_pix(d, 1'b1);
    n_total++;
    if ({o_sof_err, o_wr_b1_en, o_wr_b2_en, o_wr_addr, o_wr_data} !== {3'b110, 12'h800, exp_data(d)}) $display("FAIL resync_write got=%h want=%h", {o_sof_err, o_wr_b1_en, o_wr_b2_en, o_wr_addr, o_wr_data}, {3'b110, 12'h800, exp_data(d)});
    else n_pass++;
    for (int n = 1; n < NPIX; n++) begin
      d = 12'($urandom);
      drive_pix(d, 1'b0);
      obs = {o_wr_b1_en, o_wr_b2_en, o_wr_addr, o_wr_data};
      n_total++;
      if (obs !== exp_write(n, d)) $display("FAIL post_resync_write n=%0d got=%h want=%h", n, obs, exp_write(n, d));
      else n_pass++;
    end
    n_total++;
    if ({o_swap_pending, o_pix_ready} !== 2'b10) $display("FAIL resync_frame_end got=%b want=10", {o_swap_pending, o_pix_ready});
    else n_pass++;
    pulse_frame_done();
    mdl_page = ~mdl_page;
    n_total++;
    if ({o_display_page, o_sof_err} !== {mdl_page, 1'b1}) $display("FAIL sticky_err_after_swap got=%b want=%b", {o_display_page, o_sof_err}, {mdl_page, 1'b1});
    else n_pass++;
  endtask

  task automatic test_idle_drop();
    for (int k = 0; k < 8; k++) begin
      drive_pix(12'($urandom), 1'b0);
      n_total++;
      if ({o_pix_ready, o_wr_b1_en, o_wr_b2_en} !== 3'b100) $display("FAIL idle_drop k=%0d got=%b want=100", k, {o_pix_ready, o_wr_b1_en, o_wr_b2_en});
      else n_pass++;
    end
    pulse_frame_done();
    n_total++;
    if (o_display_page !== mdl_page) $display("FAIL idle_fd_ignored got=%b want=%b", o_display_page, mdl_page);
    else n_pass++;
  endtask

  task automatic test_gamma();
    logic [11:0] d;
    logic [11:0] want_g;
`ifdef LED_FB_GAMMA_EN
    want_g = 12'h361;
`else
    want_g = 12'h7A4;
`endif
    drive_pix(12'h7A4, 1'b1);
    n_total++;
    if ({o_wr_b1_en, o_wr_data} !== {1'b1, want_g}) $display("FAIL gamma_7a4 got=%h want=%h", {o_wr_b1_en, o_wr_data}, {1'b1, want_g});
    else n_pass++;
    for (int n = 1; n <= 20; n++) begin
      d = 12'($urandom);
      drive_pix(d, 1'b0);
      n_total++;
      if ({o_wr_b1_en, o_wr_b2_en, o_wr_addr, o_wr_data} !== exp_write(n, d)) $display("FAIL gamma_rand n=%0d got=%h want=%h", n, {o_wr_b1_en, o_wr_b2_en, o_wr_addr, o_wr_data}, exp_write(n, d));
      else n_pass++;
    end
  endtask

  // Continues the frame opened by test_gamma (next position 21).
  task automatic test_reset_midframe();
    logic [29:0] obs;
    logic [11:0] d;
    drive_pix(12'($urandom), 1'b0);
    n_total++;
    if (o_wr_b1_en !== 1'b1) $display("FAIL inflight_strobe got=%b want=1", o_wr_b1_en);
    else n_pass++;
    #2 i_rst = 1'b1;
    #1;
    obs = {o_pix_ready, o_display_page, o_wr_addr, o_wr_data, o_wr_b1_en, o_wr_b2_en, o_swap_pending, o_sof_err};
    n_total++;
    if (obs !== {1'b1, 1'b0, 12'h0, 12'h0, 4'b0000}) $display("FAIL async_reset got=%h want=%h", obs, {1'b1, 1'b0, 12'h0, 12'h0, 4'b0000});
    else n_pass++;
    mdl_page = 1'b0;
    @(posedge i_clk); @(posedge i_clk); #1;
    i_rst = 1'b0;
    drive_pix(12'($urandom), 1'b0);
    n_total++;
    if ({o_wr_b1_en, o_wr_b2_en} !== 2'b00) $display("FAIL post_reset_idle got=%b want=00", {o_wr_b1_en, o_wr_b2_en});
    else n_pass++;
    d = 12'($urandom);
    drive_pix(d, 1'b1);
    n_total++;
    if ({o_wr_b1_en, o_wr_addr, o_wr_data} !== {1'b1, 12'h800, exp_data(d)}) $display("FAIL post_reset_sof got=%h want=%h", {o_wr_b1_en, o_wr_addr, o_wr_data}, {1'b1, 12'h800, exp_data(d)});
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_swap();
    test_early_frame_done();
    test_resync();
    test_idle_drop();
    test_gamma();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout passed=%0d total=%0d", n_pass, n_total);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
